// File: rtl/halt_ctrl_pkg.sv
// Shared definitions for the run/halt controller: counter width common with
// the clock divider and the FSM state encoding shown on the debug LEDs.
package halt_ctrl_pkg;

    localparam int CNT_W = 28;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_HALTED = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_UNUSED = 2'b11;

endpackage

// File: rtl/halt_ctrl_if.sv
// Board/processor side signal bundle of the run/halt controller.
// master = whoever drives the raw inputs (board, bench), slave = halt_ctrl.
interface halt_ctrl_if;

    logic       btnCont;
    logic       btnStep;
    logic       modoStep;
    logic       hltInstr;
    logic       halt;
    logic [1:0] estado;
    logic       passo;

    modport master (
        output btnCont, btnStep, modoStep, hltInstr,
        input  halt, estado, passo
    );

    modport slave (
        input  btnCont, btnStep, modoStep, hltInstr,
        output halt, estado, passo
    );

endinterface

// File: rtl/halt_ctrl_btn_debounce.sv
// Conditioning for one asynchronous board input: polarity correction, 2-flop
// synchronizer, stability-count debounce and a one-cycle rising-edge pulse.
// Polarity is corrected before the synchronizer so that every register reset
// value of 0 means "not pressed".
module btn_debounce
    import halt_ctrl_pkg::*;
#(
    parameter cnt_t DEB_CYCLES = 28'd500000,
    parameter logic INVERT     = 1'b0
) (
    input  logic entClk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic deb_r;
    logic deb_d_r;
    cnt_t cnt_r;

    // Bring the raw input into the entClk domain.
    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw ^ INVERT;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            deb_r <= 1'b0;
            cnt_r <= 28'd0;
        end else if (sync2_r != deb_r) begin
            if ((cnt_r + 28'd1) >= DEB_CYCLES) begin
                deb_r <= sync2_r;
                cnt_r <= 28'd0;
            end else begin
                cnt_r <= cnt_r + 28'd1;
            end
        end else begin
            cnt_r <= 28'd0;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            deb_d_r <= 1'b0;
        end else begin
            deb_d_r <= deb_r;
        end
    end

    assign level = deb_r;
    assign rise  = deb_r & ~deb_d_r;

endmodule

// File: rtl/halt_ctrl.sv
// Run/halt controller for the processor clock divider. Merges the HLT
// instruction flag, the continue button and single-step button/switch into a
// registered halt level. A single step releases the divider for exactly
// STEP_CYCLES entClk cycles and then re-halts, pulsing passo.
module halt_ctrl
    import halt_ctrl_pkg::*;
#(
    parameter cnt_t DEB_CYCLES     = 28'd500000,
    parameter cnt_t STEP_CYCLES    = 28'd2,
    parameter logic BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       entClk,
    input  logic       rst,
    halt_ctrl_if.slave bus
);

    logic       press_cont_s;
    logic       press_step_s;
    logic       modo_lvl_s;
    logic       cont_lvl_unused_s;
    logic       step_lvl_unused_s;
    logic       modo_rise_unused_s;
    logic       hlt_d_r;
    logic       hlt_rise_s;
    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    cnt_t       step_cnt_r;
    cnt_t       step_cnt_nx_s;
    logic       passo_nx_s;
    logic       halt_r;
    logic       passo_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .INVERT(BTN_ACTIVE_LOW)) u_cont (
        .entClk (entClk),
        .rst    (rst),
        .raw    (bus.btnCont),
        .level  (cont_lvl_unused_s),
        .rise   (press_cont_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .INVERT(BTN_ACTIVE_LOW)) u_step (
        .entClk (entClk),
        .rst    (rst),
        .raw    (bus.btnStep),
        .level  (step_lvl_unused_s),
        .rise   (press_step_s)
    );

    // The mode switch is a level, never inverted.
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b0)) u_modo (
        .entClk (entClk),
        .rst    (rst),
        .raw    (bus.modoStep),
        .level  (modo_lvl_s),
        .rise   (modo_rise_unused_s)
    );

    // Remember the previous HLT flag so a held level yields one event.
    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            hlt_d_r <= 1'b0;
        end else begin
            hlt_d_r <= bus.hltInstr;
        end
    end

    assign hlt_rise_s = bus.hltInstr & ~hlt_d_r;

    // Next-state, step counter and step-done decisions.
    always_comb begin
        state_nx_s    = state_r;
        step_cnt_nx_s = step_cnt_r;
        passo_nx_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hlt_rise_s || modo_lvl_s) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (press_step_s) begin
                    state_nx_s    = ST_STEP;
                    step_cnt_nx_s = STEP_CYCLES;
                end else if (press_cont_s && !modo_lvl_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_HALTED;
                end
            end
            ST_STEP: begin
                // <= 1 also covers a zero STEP_CYCLES so the counter never wraps.
                if (step_cnt_r <= 28'd1) begin
                    state_nx_s    = ST_HALTED;
                    step_cnt_nx_s = 28'd0;
                    passo_nx_s    = 1'b1;
                end else begin
                    state_nx_s    = ST_STEP;
                    step_cnt_nx_s = step_cnt_r - 28'd1;
                end
            end
            default: begin
                state_nx_s    = ST_HALTED;
                step_cnt_nx_s = 28'd0;
            end
        endcase
    end

    // State, counter and outputs all update on the same edge.
    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            step_cnt_r <= 28'd0;
            halt_r     <= 1'b0;
            passo_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            step_cnt_r <= step_cnt_nx_s;
            halt_r     <= (state_nx_s == ST_HALTED);
            passo_r    <= passo_nx_s;
        end
    end

    assign bus.halt   = halt_r;
    assign bus.estado = state_r;
    assign bus.passo  = passo_r;

endmodule
